pc_sequencer: RTL and testbench

- Pipeline controller that decides, every cycle, which next-PC source the program counter loads.
- Arbitrates between sequential fetch, taken branch (EX), jump and jump-register (ID), external interrupt and undefined-instruction exception.
- Drives PC write-enable and the IF/ID and ID/EX flush/stall controls. Owns the interrupt synchronizer, pending latch and post-trap masking.
- Sits in the pipeline top between the hazard/decode logic and the program counter.

---
 rtl/pc_sequencer_pkg.sv | 25 ++
 rtl/pc_sequencer_irq_sync.sv | 29 ++
 rtl/pc_sequencer.sv | 112 +++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the next-PC sequencer: PC select codes, EPC select codes,
// trap vector addresses and the sequencer FSM state type.
package pc_sequencer_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_BR  = 3'b001;
  localparam logic [2:0] PCSRC_J   = 3'b010;
  localparam logic [2:0] PCSRC_JR  = 3'b011;
  localparam logic [2:0] PCSRC_IRQ = 3'b100;
  localparam logic [2:0] PCSRC_EXC = 3'b101;

  localparam logic [1:0] EPC_NONE = 2'b00;
  localparam logic [1:0] EPC_ID   = 2'b01;
  localparam logic [1:0] EPC_IF   = 2'b10;
  localparam logic [1:0] EPC_BTGT = 2'b11;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_irq_sync.sv
// Multi-flop synchronizer for the asynchronous irq level, followed by a pending
// latch that holds until the sequencer takes the interrupt.
module pc_sequencer_irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  input  logic i_clr,
  output logic o_pend
);

  logic [STAGES-1:0] r_sync;
  logic              r_pend;

  // Clear wins over a still-high synchronized level; a held level re-arms next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_pend <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_pend <= i_clr ? 1'b0 : (r_pend | r_sync[STAGES-1]);
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC source arbiter: picks branch/exception/irq/jr/jump/stall/sequential each
// cycle and masks new traps for a few cycles after a vector redirect.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES  = 2,
  parameter int TRAP_HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pc_kernel,
  input  logic       irq,
  input  logic       branch_ex,
  input  logic       branch_cond,
  input  logic       jump_id,
  input  logic       jr_id,
  input  logic       undef_id,
  input  logic       load_use,
  output logic [2:0] PCSrc,
  output logic       pc_write,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic [1:0] epc_sel,
  output logic       irq_ack
);

  localparam int CW = (TRAP_HOLD_CYCLES > 1) ? $clog2(TRAP_HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(TRAP_HOLD_CYCLES - 1);

  seq_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_irq_ack;
  logic          w_pend, w_take_irq, w_take_exc;

  pc_sequencer_irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_irq_sync (
    .clk     (clk),
    .rst     (reset),
    .i_async (irq),
    .i_clr   (w_take_irq),
    .o_pend  (w_pend)
  );

  // Irq is refused while any branch sits in EX or a load-use stall is active,
  // so the saved IF PC is always the true next instruction.
  always_comb begin
    PCSrc      = PCSRC_SEQ;
    pc_write   = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    epc_sel    = EPC_NONE;
    w_take_exc = 1'b0;
    w_take_irq = 1'b0;
    if (branch_ex && branch_cond) begin
      PCSrc      = PCSRC_BR;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (undef_id && r_state != ST_HOLD) begin
      PCSrc      = PCSRC_EXC;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      epc_sel    = EPC_ID;
      w_take_exc = 1'b1;
    end else if (w_pend && !pc_kernel && r_state == ST_RUN && !branch_ex && !load_use) begin
      PCSrc      = PCSRC_IRQ;
      flush_ifid = 1'b1;
      epc_sel    = EPC_IF;
      w_take_irq = 1'b1;
    end else if (jr_id && !load_use) begin
      PCSrc      = PCSRC_JR;
      flush_ifid = 1'b1;
    end else if (jump_id) begin
      PCSrc      = PCSRC_J;
      flush_ifid = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      flush_idex = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_take_exc || w_take_irq) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) w_state_nxt = ST_RUN;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_irq_ack <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_irq_ack <= w_take_irq;
    end
  end

  assign irq_ack = r_irq_ack;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + random bench for pc_sequencer against a cycle-level rule model
// (irq delay queue, pending flag, remaining-hold-cycles counter).
module tb_pc_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic reset, pc_kernel, irq, branch_ex, branch_cond, jump_id, jr_id, undef_id, load_use;
  logic [2:0] PCSrc;
  logic       pc_write, flush_ifid, flush_idex, irq_ack;
  logic [1:0] epc_sel;

  pc_sequencer #(.IRQ_SYNC_STAGES(SYNC), .TRAP_HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .pc_kernel(pc_kernel), .irq(irq),
    .branch_ex(branch_ex), .branch_cond(branch_cond), .jump_id(jump_id),
    .jr_id(jr_id), .undef_id(undef_id), .load_use(load_use),
    .PCSrc(PCSrc), .pc_write(pc_write), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .epc_sel(epc_sel), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  bit hist[$];
  bit m_pend, m_ack, e_take_irq, e_trap;
  int m_hold;

  logic [2:0] obs_pcsrc;
  logic       obs_pw, obs_fi, obs_fe, obs_ack;
  logic [1:0] obs_epc;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_expect(output logic [8:0] e);
    logic [2:0] src;
    logic       pw, fi, fe;
    logic [1:0] ep;
    src = 3'd0; pw = 1'b1; fi = 1'b0; fe = 1'b0; ep = 2'd0;
    e_take_irq = 1'b0; e_trap = 1'b0;
    if (branch_ex && branch_cond) begin
      src = 3'd1; fi = 1'b1; fe = 1'b1;
    end else if (undef_id && m_hold == 0) begin
      src = 3'd5; fi = 1'b1; fe = 1'b1; ep = 2'd1; e_trap = 1'b1;
    end else if (m_pend && !pc_kernel && m_hold == 0 && !branch_ex && !load_use) begin
      src = 3'd4; fi = 1'b1; ep = 2'd2; e_take_irq = 1'b1; e_trap = 1'b1;
    end else if (jr_id && !load_use) begin
      src = 3'd3; fi = 1'b1;
    end else if (jump_id) begin
      src = 3'd2; fi = 1'b1;
    end else if (load_use) begin
      pw = 1'b0; fe = 1'b1;
    end
    e = {src, pw, fi, fe, ep, m_ack};
  endtask

  task automatic model_update();
    bit synced;
    synced = hist[0];
    m_pend = e_take_irq ? 1'b0 : (m_pend | synced);
    void'(hist.pop_front());
    hist.push_back(irq);
    m_ack = e_take_irq;
    if (e_trap) m_hold = HOLD;
    else if (m_hold > 0) m_hold--;
  endtask

  task automatic model_reset();
    hist = {};
    repeat (SYNC) hist.push_back(1'b0);
    m_pend = 0; m_ack = 0; m_hold = 0; e_take_irq = 0; e_trap = 0;
  endtask

  task automatic step(input string tag, input bit bex, bc, jid, jrid, und, lu, iq, kern);
    logic [8:0] e, o;
    @(negedge clk);
    branch_ex = bex; branch_cond = bc; jump_id = jid; jr_id = jrid;
    undef_id = und; load_use = lu; irq = iq; pc_kernel = kern;
    #1;
    model_expect(e);
    o = {PCSrc, pc_write, flush_ifid, flush_idex, epc_sel, irq_ack};
    obs_pcsrc = PCSrc; obs_pw = pc_write; obs_fi = flush_ifid;
    obs_fe = flush_idex; obs_epc = epc_sel; obs_ack = irq_ack;
    chk(tag, {7'd0, o}, {7'd0, e});
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    branch_ex = 0; branch_cond = 0; jump_id = 0; jr_id = 0;
    undef_id = 0; load_use = 0; irq = 0; pc_kernel = 0;
    model_reset();
    #1;
    chk("rst_pcsrc", {13'd0, PCSrc}, 16'd0);
    chk("rst_pcwrite_flush", {13'd0, pc_write, flush_ifid, flush_idex}, 16'b100);
    chk("rst_epc_ack", {13'd0, epc_sel, irq_ack}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_update();
  endtask

  initial begin
    bit r_irq, r_kern;
    reset = 1'b1;
    branch_ex = 0; branch_cond = 0; jump_id = 0; jr_id = 0;
    undef_id = 0; load_use = 0; irq = 0; pc_kernel = 0;
    model_reset();
    do_reset();

    // irq on an idle pipe: taken SYNC+1 cycles after the rise, held level re-taken after HOLD
    step("irq_c0", 0,0,0,0,0,0,1,0);
    step("irq_c1", 0,0,0,0,0,0,1,0);
    step("irq_c2", 0,0,0,0,0,0,1,0);
    chk("irq_not_early", {13'd0, obs_pcsrc}, 16'd0);
    step("irq_c3", 0,0,0,0,0,0,1,0);
    chk("irq_latency", {13'd0, obs_pcsrc}, 16'd4);
    chk("irq_epc", {14'd0, obs_epc}, 16'd2);
    step("irq_c4", 0,0,0,0,0,0,1,0);
    chk("irq_ack_pulse", {15'd0, obs_ack}, 16'd1);
    chk("irq_hold1", {13'd0, obs_pcsrc}, 16'd0);
    step("irq_c5", 0,0,0,0,0,0,1,0);
    chk("irq_hold2", {13'd0, obs_pcsrc}, 16'd0);
    chk("irq_ack_single", {15'd0, obs_ack}, 16'd0);
    step("irq_c6", 0,0,0,0,0,0,1,0);
    chk("irq_retake", {13'd0, obs_pcsrc}, 16'd4);
    repeat (8) step("irq_drain", 0,0,0,0,0,0,0,0);
    do_reset();

    // branch overrides undef and a pending irq, without entering HOLD
    repeat (4) step("pend_k", 0,0,0,0,0,0,1,1);
    step("br_over", 1,1,0,0,1,0,0,0);
    chk("br_pcsrc", {13'd0, obs_pcsrc}, 16'd1);
    chk("br_flush_epc", {12'd0, obs_fi, obs_fe, obs_epc}, 16'b1100);
    step("br_after", 0,0,0,0,0,0,0,0);
    chk("br_no_hold", {13'd0, obs_pcsrc}, 16'd4);
    repeat (6) step("drain2", 0,0,0,0,0,0,0,0);
    do_reset();

    // load-use stalls jr, then jr proceeds
    step("lu_jr", 0,0,0,1,0,1,0,0);
    chk("lu_jr_stall", {12'd0, obs_pcsrc, obs_pw}, {12'd0, 3'd0, 1'b0});
    chk("lu_jr_flush", {14'd0, obs_fi, obs_fe}, 16'b01);
    step("jr_go", 0,0,0,1,0,0,0,0);
    chk("jr_go_src", {12'd0, obs_pcsrc, obs_fi}, {12'd0, 3'd3, 1'b1});
    step("lu_jump", 0,0,1,0,0,1,0,0);

    // undef traps in RUN, second undef in HOLD is a double fault
    step("undef1", 0,0,0,0,1,0,0,0);
    chk("undef1_src", {12'd0, obs_pcsrc, 1'b0}, {12'd0, 3'd5, 1'b0});
    chk("undef1_epc", {14'd0, obs_epc}, 16'd1);
    step("undef2", 0,0,0,0,1,0,0,0);
    chk("undef2_seq", {13'd0, obs_pcsrc}, 16'd0);
    repeat (3) step("idle", 0,0,0,0,0,0,0,0);

    // kernel mode masks a held irq; leaving kernel takes it at once
    repeat (10) begin
      step("kern_mask", 0,0,0,0,0,0,1,1);
      chk("kern_never", {15'd0, obs_pcsrc == 3'd4}, 16'd0);
    end
    step("kern_drop", 0,0,0,0,0,0,1,0);
    chk("kern_drop_take", {13'd0, obs_pcsrc}, 16'd4);
    repeat (8) step("drain3", 0,0,0,0,0,0,0,0);

    // reset in the middle of HOLD discards the pending irq
    repeat (4) step("pend_k2", 0,0,0,0,0,0,1,1);
    step("hold_enter", 0,0,0,0,1,0,1,1);
    do_reset();
    step("post_rst", 0,0,0,0,0,0,0,0);
    chk("post_rst_out", {11'd0, obs_pcsrc, obs_pw, obs_ack}, {11'd0, 3'd0, 1'b1, 1'b0});
    repeat (5) begin
      step("post_rst_idle", 0,0,0,0,0,0,0,0);
      chk("post_rst_noirq", {15'd0, obs_pcsrc == 3'd4}, 16'd0);
    end

    // random traffic
    r_irq = 0; r_kern = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) r_irq = ~r_irq;
      if ($urandom_range(0, 9) == 0) r_kern = ~r_kern;
      if ($urandom_range(0, 199) == 0) do_reset();
      step("rand",
           $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 4) == 0,
           r_irq, r_kern);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
